// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared fetch-stage types and constants
//
// Purpose: fetch FSM state type, PC increment and default reset/trap vectors
//          shared by the program-counter fetch logic.
// Contents:
//   fetch_state_t        BOOT / FETCH / TRAP
//   PC_STEP              byte distance between sequential instructions
//   DEFAULT_RESET_VECTOR pc value after reset
//   DEFAULT_TRAP_VECTOR  pc value after a misaligned-target trap
package rv32i_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    TRAP  = 2'd2
  } fetch_state_t;

  localparam int          PC_STEP              = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_next_logic.sv
// rtl/pc_next_logic.sv - combinational next-PC select and alignment check
//
// Purpose: picks sequential pc+4 or the ALU redirect target and flags a
//          redirect target that is not word aligned.
// Ports:
//   pc          in   XLEN  current PC
//   pc_sel      in   1     0: sequential, 1: redirect to alu_target
//   alu_target  in   XLEN  branch/jump target
//   next_pc     out  XLEN  selected next PC
//   pc_plus4    out  XLEN  pc + 4, wrapping modulo 2^XLEN
//   misaligned  out  1     redirect selected and target[1:0] != 0
module pc_next_logic
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] alu_target,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned
);

  // Natural XLEN-bit overflow gives the required wrap at the top of memory.
  assign pc_plus4   = pc + XLEN'(PC_STEP);
  assign next_pc    = pc_sel ? alu_target : pc_plus4;
  // Sequential fetch cannot misalign; only a redirect target is checked.
  assign misaligned = pc_sel & (alu_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - RV32I program counter and instruction fetch control
//
// Purpose: holds the PC register, fetch FSM (BOOT/FETCH/TRAP), captured
//          misaligned target and completed-fetch counter.
// Ports:
//   clk            in   1     clock, all state on posedge
//   rst            in   1     synchronous active-high reset
//   stall          in   1     hold request; freezes PC in FETCH
//   PCSel          in   1     0: next = pc+4, 1: next = alu_target
//   alu_target     in   XLEN  branch/jump target
//   imem_ready     in   1     instruction memory completes this cycle
//   pc_out         out  XLEN  current PC (registered)
//   pc_plus4       out  XLEN  pc_out + 4
//   imem_req       out  1     fetch request valid
//   instr_valid    out  1     fetch completes this cycle
//   misalign_trap  out  1     one-cycle misaligned-target trap pulse
//   bad_pc         out  XLEN  captured offending target
//   fetch_count    out  32    completed fetches, wrapping
module pc_fetch_unit
  import rv32i_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            PCSel,
  input  logic [XLEN-1:0] alu_target,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            imem_req,
  output logic            instr_valid,
  output logic            misalign_trap,
  output logic [XLEN-1:0] bad_pc,
  output logic [31:0]     fetch_count
);

  fetch_state_t    state;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;
  logic            advance;

  pc_next_logic #(.XLEN(XLEN)) u_next (
    .pc         (pc_out),
    .pc_sel     (PCSel),
    .alu_target (alu_target),
    .next_pc    (next_pc),
    .pc_plus4   (pc_plus4),
    .misaligned (misaligned)
  );

  // Outputs decode the registered state; rst masks them in the same cycle so
  // no request or pulse escapes while reset is being applied.
  assign imem_req      = ~rst & (state == FETCH);
  assign instr_valid   = imem_req & imem_ready;
  assign misalign_trap = ~rst & (state == TRAP);

  // A stalled but ready fetch still returns valid data; only the PC holds.
  assign advance = (state == FETCH) & imem_ready & ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc_out      <= RESET_VECTOR;
      bad_pc      <= '0;
      fetch_count <= '0;
    end else begin
      case (state)
        BOOT: begin
          state <= FETCH;
        end
        FETCH: begin
          if (advance) begin
            fetch_count <= fetch_count + 32'd1;
            if (misaligned) begin
              // PC stays on the branch instruction; the trap supplies the new PC.
              bad_pc <= alu_target;
              state  <= TRAP;
            end else begin
              pc_out <= next_pc;
            end
          end
        end
        TRAP: begin
          pc_out <= TRAP_VECTOR;
          state  <= FETCH;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        PCSel;
  logic [31:0] alu_target;
  logic        imem_ready;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic        instr_valid;
  logic        misalign_trap;
  logic [31:0] bad_pc;
  logic [31:0] fetch_count;

  int errors = 0;
  int checks = 0;

  pc_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .PCSel         (PCSel),
    .alu_target    (alu_target),
    .imem_ready    (imem_ready),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .imem_req      (imem_req),
    .instr_valid   (instr_valid),
    .misalign_trap (misalign_trap),
    .bad_pc        (bad_pc),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the observable contract of the fetch stage.
  bit          m_live = 0;   // a reset edge has been seen
  bit          m_boot;       // first cycle after reset release, no request yet
  bit          m_trap;       // trap cycle pending
  logic [31:0] m_pc, m_bad, m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1; m_boot = 1; m_trap = 0;
      m_pc = 32'h0; m_bad = 32'h0; m_cnt = 32'h0;
    end else if (m_live) begin
      if (m_trap) begin
        m_trap = 0;
        m_pc   = 32'h0000_0100;
      end else if (m_boot) begin
        m_boot = 0;
      end else if (imem_ready && !stall) begin
        m_cnt = m_cnt + 1;
        if (!PCSel)                    m_pc = m_pc + 4;
        else if (alu_target % 4 == 0)  m_pc = alu_target;
        else begin
          m_bad  = alu_target;
          m_trap = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      automatic logic req = !rst && !m_boot && !m_trap;
      chk("m_pc_out",      pc_out,        m_pc);
      chk("m_pc_plus4",    pc_plus4,      m_pc + 32'd4);
      chk("m_imem_req",    {31'b0, imem_req},      {31'b0, req});
      chk("m_instr_valid", {31'b0, instr_valid},   {31'b0, req && imem_ready});
      chk("m_trap",        {31'b0, misalign_trap}, {31'b0, !rst && m_trap});
      chk("m_bad_pc",      bad_pc,        m_bad);
      chk("m_fetch_count", fetch_count,   m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; PCSel = 1'b0; alu_target = 32'h0; imem_ready = 1'b0;
    tick(); tick();
    chk("rst_pc",    pc_out,      32'h0);
    chk("rst_cnt",   fetch_count, 32'h0);
    chk("rst_req",   {31'b0, imem_req}, 32'h0);
    chk("rst_bad",   bad_pc,      32'h0);

    // 1. reset release: one boot cycle without a request, then sequential fetch
    rst = 1'b0; imem_ready = 1'b1;
    #1 chk("boot_req", {31'b0, imem_req}, 32'h0);
    tick();
    chk("fetch_req",  {31'b0, imem_req},    32'h1);
    chk("fetch_pc0",  pc_out,               32'h0);
    chk("fetch_iv",   {31'b0, instr_valid}, 32'h1);
    tick(); chk("seq_pc4", pc_out, 32'h4); chk("seq_cnt1", fetch_count, 32'd1);
    tick(); chk("seq_pc8", pc_out, 32'h8); chk("seq_cnt2", fetch_count, 32'd2);

    // 2. stall with ready memory: data valid, PC frozen
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc",  pc_out,               32'h8);
      chk("stall_iv",  {31'b0, instr_valid}, 32'h1);
      chk("stall_cnt", fetch_count,          32'd2);
    end
    stall = 1'b0;
    tick(); chk("unstall_pc", pc_out, 32'hC); chk("unstall_cnt", fetch_count, 32'd3);

    // 3. aligned redirect
    PCSel = 1'b1; alu_target = 32'h40;
    tick(); chk("redir_pc", pc_out, 32'h40);
    PCSel = 1'b0;
    tick(); chk("redir_seq", pc_out, 32'h44); chk("redir_cnt", fetch_count, 32'd5);

    // 4. misaligned redirect traps; stall is ignored during the trap cycle
    PCSel = 1'b1; alu_target = 32'h42;
    tick();
    chk("mis_trap", {31'b0, misalign_trap}, 32'h1);
    chk("mis_req",  {31'b0, imem_req},      32'h0);
    chk("mis_bad",  bad_pc,                 32'h42);
    chk("mis_hold", pc_out,                 32'h44);
    chk("mis_cnt",  fetch_count,            32'd6);
    PCSel = 1'b0; stall = 1'b1;
    tick();
    chk("trap_vec",  pc_out,                 32'h100);
    chk("trap_end",  {31'b0, misalign_trap}, 32'h0);
    chk("trap_req",  {31'b0, imem_req},      32'h1);
    stall = 1'b0;

    // 5. wrap at the top of the address space
    PCSel = 1'b1; alu_target = 32'hFFFF_FFFC;
    tick();
    chk("wrap_top",   pc_out,   32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    PCSel = 1'b0;
    tick(); chk("wrap_pc", pc_out, 32'h0); chk("wrap_cnt", fetch_count, 32'd8);

    // 6a. memory backpressure
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_pc", pc_out, 32'h0);
      chk("bp_iv", {31'b0, instr_valid}, 32'h0);
    end
    chk("bp_cnt", fetch_count, 32'd8);
    imem_ready = 1'b1;

    // 6b. reset asserted during the trap cycle
    PCSel = 1'b1; alu_target = 32'h81;
    tick();
    chk("rt_trap", {31'b0, misalign_trap}, 32'h1);
    rst = 1'b1; PCSel = 1'b0;
    tick();
    chk("rt_pc",   pc_out,                 32'h0);
    chk("rt_trap0",{31'b0, misalign_trap}, 32'h0);
    chk("rt_cnt",  fetch_count,            32'h0);
    chk("rt_bad",  bad_pc,                 32'h0);
    rst = 1'b0;
    tick(); tick();
    chk("rt_resume", pc_out, 32'h4);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
